// File: rtl/axis_frame_gate.sv
// Purpose: gate the delayed Schmidl-Cox sample stream into one trig-aligned frame of cfg_len beats.
// Latency: zero-cycle combinational passthrough while forwarding; discarded beats produce no output.
// Backpressure: m_axis_tready drives s_axis_tready while forwarding; skip/idle phases always accept; flush stalls input for one cycle.
module axis_frame_gate #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] cfg_offset,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             trig,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             delay_clear,
  output logic             busy,
  output logic             trig_dropped,
  output logic             truncated
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFSET = 2'd1,
    ST_PASS   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] off_cnt;
  logic [CNT_W-1:0] len_cnt;
  logic [CNT_W-1:0] lat_off;
  logic [CNT_W-1:0] lat_len;
  // Held low through reset so the input side does not look ready while the
  // block is being reset; rises on the first clock after reset release.
  logic             live;

  logic in_beat;
  logic off_end;
  logic len_end;

  assign in_beat = s_axis_tvalid && s_axis_tready;
  // Last discarded beat before the frame: offset is at least 1 in OFFSET.
  assign off_end = (off_cnt == (lat_off - ONE));
  // Last beat of the frame: latched length is at least 1 in PASS.
  assign len_end = (len_cnt == (lat_len - ONE));

  // Handshake and datapath steering: only PASS connects the two sides.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    unique case (state)
      ST_IDLE, ST_OFFSET: begin
        s_axis_tready = live;
      end
      ST_PASS: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = len_end || s_axis_tlast;
      end
      default: begin
        s_axis_tready = 1'b0;
      end
    endcase
  end

  // Frame sequencer: state, counters, latched config and registered status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      off_cnt      <= '0;
      len_cnt      <= '0;
      lat_off      <= '0;
      lat_len      <= '0;
      live         <= 1'b0;
      busy         <= 1'b0;
      delay_clear  <= 1'b0;
      trig_dropped <= 1'b0;
      truncated    <= 1'b0;
    end else begin
      live         <= 1'b1;
      delay_clear  <= 1'b0;
      trig_dropped <= 1'b0;
      truncated    <= 1'b0;
      if (clear) begin
        // Clear wins over everything, including a trig in the same cycle,
        // and deliberately does not pulse delay_clear.
        state   <= ST_IDLE;
        off_cnt <= '0;
        len_cnt <= '0;
        busy    <= 1'b0;
      end else begin
        // A trig is only usable in IDLE with a non-empty frame; anything
        // else is reported and otherwise ignored (no re-arm, no reload).
        if (trig && ((state != ST_IDLE) || (cfg_len == '0))) begin
          trig_dropped <= 1'b1;
        end
        unique case (state)
          ST_IDLE: begin
            // Beats here are discarded, including one coinciding with trig.
            if (trig && (cfg_len != '0)) begin
              lat_off <= cfg_offset;
              lat_len <= cfg_len;
              off_cnt <= '0;
              len_cnt <= '0;
              busy    <= 1'b1;
              state   <= (cfg_offset == '0) ? ST_PASS : ST_OFFSET;
            end
          end
          ST_OFFSET: begin
            if (in_beat) begin
              if (s_axis_tlast) begin
                // Input packet ended before the frame could start.
                truncated   <= 1'b1;
                delay_clear <= 1'b1;
                state       <= ST_FLUSH;
              end else begin
                off_cnt <= off_cnt + ONE;
                if (off_end) begin
                  state <= ST_PASS;
                end
              end
            end
          end
          ST_PASS: begin
            // Backpressure simply stalls here; only real handshakes count.
            if (in_beat) begin
              len_cnt <= len_cnt + ONE;
              if (m_axis_tlast) begin
                delay_clear <= 1'b1;
                state       <= ST_FLUSH;
                if (!len_end) begin
                  truncated <= 1'b1;
                end
              end
            end
          end
          default: begin
            // FLUSH: one cycle with delay_clear high and input stalled.
            state   <= ST_IDLE;
            off_cnt <= '0;
            len_cnt <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_gate.sv
// Purpose: scoreboard bench for axis_frame_gate with directed frame scenarios.
// Latency: expected beats are queued ahead of stimulus and popped by a negedge monitor.
// Backpressure: m_axis_tready is held high or toggled per cycle by a dedicated process.
module tb_axis_frame_gate;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic [CNT_W-1:0] cfg_offset;
  logic [CNT_W-1:0] cfg_len;
  logic             trig;
  logic [WIDTH-1:0] s_tdata;
  logic             s_tlast;
  logic             s_tvalid;
  logic             s_tready;
  logic [WIDTH-1:0] m_tdata;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_rdy = 1'b1;
  logic             delay_clear;
  logic             busy;
  logic             trig_dropped;
  logic             truncated;
  logic             tog_en = 1'b0;

  always #5 clk = ~clk;

  axis_frame_gate #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .cfg_offset    (cfg_offset),
    .cfg_len       (cfg_len),
    .trig          (trig),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_rdy),
    .delay_clear   (delay_clear),
    .busy          (busy),
    .trig_dropped  (trig_dropped),
    .truncated     (truncated)
  );

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             l;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    last_hs_cyc = -1;
  int    dc_cyc = -1;
  int    trunc_cyc = -1;
  int    busy_fall_cyc = -1;
  int    dc_cnt = 0;
  int    trunc_cnt = 0;
  int    drop_cnt = 0;
  logic  busy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output ready: constant 1, or alternating while tog_en is set.
  always @(posedge clk) begin
    #1;
    if (tog_en) m_rdy = ~m_rdy;
    else        m_rdy = 1'b1;
  end

  // Monitor: every output handshake is popped from the scoreboard and compared.
  initial forever begin
    @(negedge clk);
    if (m_tvalid && m_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat: got data=%0d last=%0b, required no beat", m_tdata, m_tlast);
      end else begin
        e = exp_q.pop_front();
        if (m_tdata !== e.d || m_tlast !== e.l) begin
          failures++;
          $display("FAIL beat: got data=%0d last=%0b, required data=%0d last=%0b", m_tdata, m_tlast, e.d, e.l);
        end
      end
      if (m_tlast) last_hs_cyc = cyc;
    end
    if (delay_clear)  begin dc_cnt++;    dc_cyc = cyc;    end
    if (truncated)    begin trunc_cnt++; trunc_cyc = cyc; end
    if (trig_dropped) drop_cnt++;
    if (busy_q && !busy) busy_fall_cyc = cyc;
    busy_q = busy;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input logic l);
    beat_t b;
    b.d = WIDTH'(d);
    b.l = l;
    exp_q.push_back(b);
  endtask

  // Present one input beat and hold it until it is accepted (bounded).
  task automatic send(input int d, input logic l);
    logic acc;
    int   n;
    n        = 0;
    s_tvalid = 1'b1;
    s_tdata  = WIDTH'(d);
    s_tlast  = l;
    forever begin
      @(negedge clk);
      acc = s_tready;
      tick();
      if (acc) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: beat %0d not accepted in 50 cycles, required acceptance", d);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic do_trig(input int off, input int len);
    cfg_offset = CNT_W'(off);
    cfg_len    = CNT_W'(len);
    trig       = 1'b1;
    tick();
    trig       = 1'b0;
  endtask

  int dc0, tr0, dr0;

  initial begin
    reset = 1'b0; clear = 1'b0; trig = 1'b0;
    cfg_offset = '0; cfg_len = '0;
    s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_s_tready", int'(s_tready), 0);
    chk("rst_m_tvalid", int'(m_tvalid), 0);
    chk("rst_m_tlast_tdata", int'({m_tlast, m_tdata != '0}), 0);
    chk("rst_pulses_busy", int'({delay_clear, busy, trig_dropped, truncated}), 0);
    reset = 1'b1;
    tick();
    tick();
    chk("idle_s_tready", int'(s_tready), 1);

    // 1: reset asserted mid-frame after 3 of 8 beats
    push_exp(400, 1'b0); push_exp(401, 1'b0); push_exp(402, 1'b0);
    do_trig(0, 8);
    for (int i = 0; i < 3; i++) send(400 + i, 1'b0);
    s_tvalid = 1'b1; s_tdata = WIDTH'(403);
    #2;
    reset = 1'b0;
    #1;
    chk("t1_m_tvalid", int'(m_tvalid), 0);
    chk("t1_s_tready", int'(s_tready), 0);
    chk("t1_m_tdata", int'(m_tdata), 0);
    chk("t1_busy", int'(busy), 0);
    s_tvalid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("t1_busy_after", int'(busy), 0);
    for (int i = 0; i < 5; i++) send(410 + i, 1'b0);
    tick();
    chk("t1_q_empty", exp_q.size(), 0);

    // 2: offset 4, length 8, continuous stream 0..19
    dc0 = dc_cnt; tr0 = trunc_cnt;
    for (int i = 4; i <= 11; i++) push_exp(i, (i == 11));
    do_trig(4, 8);
    for (int i = 0; i < 20; i++) send(i, 1'b0);
    repeat (3) tick();
    chk("t2_q_empty", exp_q.size(), 0);
    chk("t2_dc_count", dc_cnt - dc0, 1);
    chk("t2_dc_timing", dc_cyc - last_hs_cyc, 1);
    chk("t2_busy_fall", busy_fall_cyc - dc_cyc, 1);
    chk("t2_no_trunc", trunc_cnt - tr0, 0);

    // 3: offset 0, length 5, output ready toggling
    dc0 = dc_cnt;
    tog_en = 1'b1;
    for (int i = 0; i < 5; i++) push_exp(100 + i, (i == 4));
    do_trig(0, 5);
    for (int i = 0; i < 10; i++) send(100 + i, 1'b0);
    tog_en = 1'b0;
    repeat (3) tick();
    chk("t3_q_empty", exp_q.size(), 0);
    chk("t3_dc_count", dc_cnt - dc0, 1);

    // 4: length 10 truncated by input tlast on the 3rd passed beat
    dc0 = dc_cnt; tr0 = trunc_cnt;
    push_exp(202, 1'b0); push_exp(203, 1'b0); push_exp(204, 1'b1);
    do_trig(2, 10);
    for (int i = 0; i < 4; i++) send(200 + i, 1'b0);
    send(204, 1'b1);
    send(205, 1'b0);
    send(206, 1'b0);
    repeat (3) tick();
    chk("t4_q_empty", exp_q.size(), 0);
    chk("t4_trunc_count", trunc_cnt - tr0, 1);
    chk("t4_trunc_timing", trunc_cyc - last_hs_cyc, 1);
    chk("t4_dc_count", dc_cnt - dc0, 1);
    chk("t4_busy", int'(busy), 0);

    // 5: second trig during PASS is dropped, frame of 6 completes
    dr0 = drop_cnt;
    for (int i = 1; i <= 6; i++) push_exp(300 + i, (i == 6));
    do_trig(1, 6);
    fork
      begin
        for (int i = 0; i < 10; i++) send(300 + i, 1'b0);
      end
      begin
        repeat (3) tick();
        cfg_offset = '0;
        cfg_len    = CNT_W'(2);
        trig       = 1'b1;
        tick();
        trig       = 1'b0;
      end
    join
    repeat (2) tick();
    chk("t5_q_empty", exp_q.size(), 0);
    chk("t5_drop_busy", drop_cnt - dr0, 1);
    dr0 = drop_cnt;
    do_trig(0, 0);
    tick();
    chk("t5_len0_busy", int'(busy), 0);
    tick();
    chk("t5_len0_busy2", int'(busy), 0);
    chk("t5_len0_drop", drop_cnt - dr0, 1);

    // 6: clear during OFFSET with a trig in the same cycle
    do_trig(5, 3);
    send(500, 1'b0);
    send(501, 1'b0);
    dc0 = dc_cnt; dr0 = drop_cnt;
    clear = 1'b1; trig = 1'b1; cfg_offset = '0; cfg_len = CNT_W'(3);
    tick();
    clear = 1'b0; trig = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_delay_clear", int'(delay_clear), 0);
    chk("t6_no_pulses", int'({trig_dropped, truncated}), 0);
    repeat (3) tick();
    chk("t6_busy_later", int'(busy), 0);
    chk("t6_drop_count", drop_cnt - dr0, 0);
    chk("t6_dc_count", dc_cnt - dc0, 0);
    for (int i = 0; i < 4; i++) send(510 + i, 1'b0);
    tick();
    chk("t6_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
